// File: rtl/fifo_rd_skid_pkg.sv
// Shared constants for the FIFO read-side skid buffer: FSM encoding and tagged-word layout.
package fifo_rd_skid_pkg;

  localparam int DATA_W  = 32;
  localparam int TAG_BIT = 32;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Skid buffer between an upstream FIFO read port and the fetch stage; a word is visible one cycle after capture.
// Registered stop rises one entry early, so one in-flight word still fits; flush discards everything, then holds stop.
module fifo_rd_skid
  import fifo_rd_skid_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HOLDcyc = 3
) (
  input  logic              clkHI,
  input  logic              rst,
  input  logic [DATA_W:0]   inData,
  output logic              stop,
  input  logic              flush,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady,
  output logic [15:0]       wordCnt,
  output logic              overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST_LVL = CW'(DEPTH - 1);
  localparam logic [3:0]    HOLD_LD    = 4'(HOLDcyc);

  logic [1:0]    state, state_nxt;
  logic [3:0]    hold_cnt, hold_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  word_t         mem [DEPTH];

  logic in_vld, run, pop, push_req, push, drop, clear;

  assign in_vld   = inData[TAG_BIT];
  assign run      = (state == ST_RUN);
  assign outValid = (count != '0) && run;
  assign outData  = mem[rd_ptr];
  assign pop      = outValid && outReady;
  // A flush taken in RUN wins over any same-cycle push; the pop still completes.
  assign clear    = (run && flush) || (state == ST_FLUSH);
  assign push_req = in_vld && run && !flush;
  assign push     = push_req && ((count != FULL_LVL) || pop);
  assign drop     = push_req && (count == FULL_LVL) && !pop;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      ST_RUN: begin
        if (flush) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_nxt = ST_HOLD;
        hold_nxt  = HOLD_LD;
      end
      ST_HOLD: begin
        if (flush) begin
          hold_nxt = HOLD_LD;
        end else if (hold_cnt <= 4'd1) begin
          state_nxt = ST_RUN;
        end else begin
          hold_nxt = hold_cnt - 4'd1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clkHI or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      hold_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stop     <= 1'b1;
      wordCnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      count    <= count_nxt;
      stop     <= (count_nxt >= ALMOST_LVL) || (state_nxt != ST_RUN);
      if (pop) wordCnt <= wordCnt + 16'd1;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (drop) overflow <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clkHI) begin
    if (push) mem[wr_ptr] <= inData[DATA_W-1:0];
  end

endmodule

// File: tb/tb_fifo_rd_skid.sv
// Directed, table-driven bench for fifo_rd_skid (DEPTH=4, HOLDcyc=3).
module tb_fifo_rd_skid;

  logic        clkHI = 1'b0;
  logic        rst   = 1'b0;
  logic [32:0] inData = '0;
  logic        stop;
  logic        flush = 1'b0;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] wordCnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  fifo_rd_skid #(.DEPTH(4), .HOLDcyc(3)) dut (
    .clkHI    (clkHI),
    .rst      (rst),
    .inData   (inData),
    .stop     (stop),
    .flush    (flush),
    .outData  (outData),
    .outValid (outValid),
    .outReady (outReady),
    .wordCnt  (wordCnt),
    .overflow (overflow)
  );

  always #5 clkHI = ~clkHI;

  typedef struct {
    logic        tag;
    logic [31:0] dat;
    logic        rdy;
    logic        fl;
    logic        vld;
    logic [31:0] odat;
    logic        stp;
    logic        ovf;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [NV];

  function automatic vec_t v(input logic tag, input logic [31:0] dat, input logic rdy,
                             input logic fl, input logic vld, input logic [31:0] odat,
                             input logic stp, input logic ovf, input logic [15:0] cnt);
    vec_t r;
    r.tag = tag; r.dat = dat; r.rdy = rdy; r.fl = fl;
    r.vld = vld; r.odat = odat; r.stp = stp; r.ovf = ovf; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic tag, input logic [31:0] dat, input logic rdy, input logic fl);
    inData   = {tag, dat};
    outReady = rdy;
    flush    = fl;
  endtask

  localparam logic [31:0] A  = 32'hA000_0001, B  = 32'hB000_0002, C  = 32'hC000_0003;
  localparam logic [31:0] W0 = 32'h1111_0000, W1 = 32'h1111_0001, W2 = 32'h1111_0002;
  localparam logic [31:0] W3 = 32'h1111_0003, W4 = 32'h1111_0004;
  localparam logic [31:0] F0 = 32'h2222_0000, F1 = 32'h2222_0001, F2 = 32'h2222_0002;
  localparam logic [31:0] X  = 32'hDEAD_BEEF, H0 = 32'h4444_0000;
  localparam logic [31:0] G0 = 32'h3333_0000, G1 = 32'h3333_0001, G2 = 32'h3333_0002;
  localparam logic [31:0] G3 = 32'h3333_0003, G4 = 32'h3333_0004;

  initial begin
    int n;

    //             tag dat rdy fl  | vld odat stop ovf cnt
    vecs[0]  = v(1, A,  1, 0,  1, A,  0, 0, 0);
    vecs[1]  = v(1, B,  1, 0,  1, B,  0, 0, 1);
    vecs[2]  = v(1, C,  1, 0,  1, C,  0, 0, 2);
    vecs[3]  = v(0, 0,  1, 0,  0, 0,  0, 0, 3);
    vecs[4]  = v(1, W0, 0, 0,  1, W0, 0, 0, 3);
    vecs[5]  = v(1, W1, 0, 0,  1, W0, 0, 0, 3);
    vecs[6]  = v(1, W2, 0, 0,  1, W0, 1, 0, 3);
    vecs[7]  = v(1, W3, 0, 0,  1, W0, 1, 0, 3);
    vecs[8]  = v(0, 0,  0, 0,  1, W0, 1, 0, 3);
    vecs[9]  = v(1, W4, 0, 0,  1, W0, 1, 1, 3);
    vecs[10] = v(0, 0,  1, 0,  1, W1, 1, 1, 4);
    vecs[11] = v(0, 0,  1, 0,  1, W2, 0, 1, 5);
    vecs[12] = v(0, 0,  1, 0,  1, W3, 0, 1, 6);
    vecs[13] = v(0, 0,  1, 0,  0, 0,  0, 1, 7);
    vecs[14] = v(1, F0, 0, 0,  1, F0, 0, 1, 7);
    vecs[15] = v(1, F1, 0, 0,  1, F0, 0, 1, 7);
    vecs[16] = v(1, F2, 0, 1,  0, 0,  1, 0, 7);
    vecs[17] = v(1, X,  0, 0,  0, 0,  1, 0, 7);
    vecs[18] = v(1, X,  0, 0,  0, 0,  1, 0, 7);
    vecs[19] = v(1, X,  0, 0,  0, 0,  1, 0, 7);
    vecs[20] = v(1, X,  0, 0,  0, 0,  0, 0, 7);
    vecs[21] = v(1, G0, 0, 0,  1, G0, 0, 0, 7);
    vecs[22] = v(1, G1, 0, 0,  1, G0, 0, 0, 7);
    vecs[23] = v(1, G2, 0, 0,  1, G0, 1, 0, 7);
    vecs[24] = v(1, G3, 0, 0,  1, G0, 1, 0, 7);
    vecs[25] = v(1, G4, 1, 0,  1, G1, 1, 0, 8);
    vecs[26] = v(0, 0,  1, 0,  1, G2, 1, 0, 9);
    vecs[27] = v(0, 0,  1, 0,  1, G3, 0, 0, 10);
    vecs[28] = v(0, 0,  1, 0,  1, G4, 0, 0, 11);
    vecs[29] = v(0, 0,  1, 0,  0, 0,  0, 0, 12);
    vecs[30] = v(1, H0, 0, 0,  1, H0, 0, 0, 12);
    vecs[31] = v(1, X,  1, 1,  0, 0,  1, 0, 13);
    vecs[32] = v(0, 0,  0, 0,  0, 0,  1, 0, 13);
    vecs[33] = v(0, 0,  0, 0,  0, 0,  1, 0, 13);
    vecs[34] = v(0, 0,  0, 0,  0, 0,  1, 0, 13);
    vecs[35] = v(0, 0,  0, 0,  0, 0,  0, 0, 13);

    // Reset values while held in reset across clock edges.
    repeat (2) @(posedge clkHI);
    #1;
    chk("rst_stop",  -1, 32'(stop),     32'd1);
    chk("rst_valid", -1, 32'(outValid), 32'd0);
    chk("rst_cnt",   -1, 32'(wordCnt),  32'd0);
    chk("rst_ovf",   -1, 32'(overflow), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].tag, vecs[i].dat, vecs[i].rdy, vecs[i].fl);
      @(posedge clkHI);
      #1;
      chk("valid",    i, 32'(outValid), 32'(vecs[i].vld));
      chk("stop",     i, 32'(stop),     32'(vecs[i].stp));
      chk("overflow", i, 32'(overflow), 32'(vecs[i].ovf));
      chk("wordcnt",  i, 32'(wordCnt),  32'(vecs[i].cnt));
      if (vecs[i].vld) chk("data", i, outData, vecs[i].odat);
    end

    // Fill past capacity, then assert reset mid-cycle: outputs must change with no clock edge.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h5555_0000 + 32'(i), 1'b0, 1'b0);
      @(posedge clkHI);
      #1;
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    chk("pre_arst_ovf",   100, 32'(overflow), 32'd1);
    chk("pre_arst_valid", 100, 32'(outValid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_stop",  101, 32'(stop),     32'd1);
    chk("arst_valid", 101, 32'(outValid), 32'd0);
    chk("arst_cnt",   101, 32'(wordCnt),  32'd0);
    chk("arst_ovf",   101, 32'(overflow), 32'd0);
    #2;
    rst = 1'b1;
    @(posedge clkHI);
    #1;
    chk("release_stop", 102, 32'(stop), 32'd0);

    // Flush again while in HOLD: the hold window restarts, so stop stays up 1+1+3 cycles.
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    @(posedge clkHI);
    #1;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    n = (stop === 1'b1) ? 1 : 0;
    @(posedge clkHI);
    #1;
    if (stop === 1'b1) n++;
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    @(posedge clkHI);
    #1;
    drive(1'b1, X, 1'b0, 1'b0);
    if (stop === 1'b1) n++;
    for (int k = 0; k < 20 && stop === 1'b1; k++) begin
      @(posedge clkHI);
      #1;
      if (stop === 1'b1) n++;
    end
    chk("reflush_stop_cycles", 103, 32'(n), 32'd5);
    chk("reflush_discard", 103, 32'(outValid), 32'd0);

    // Stream resumes after the hold window.
    drive(1'b1, G0, 1'b0, 1'b0);
    @(posedge clkHI);
    #1;
    chk("resume_valid", 104, 32'(outValid), 32'd1);
    chk("resume_data",  104, outData, G0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
